// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_ctrl
// Description : Sequences a WIDTH-bit add through one shared external 4-bit
//               adder slice, one nibble per cycle, LSB first. With REDUNDANT=1
//               a second pass re-adds with operands swapped and flags any
//               nibble-sum or carry-out disagreement as a fault.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl #(
  parameter int WIDTH     = 16,
  parameter bit REDUNDANT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [3:0]       add_a_o,
  output logic [3:0]       add_b_o,
  output logic             add_cin_o,
  input  logic [3:0]       add_sum_i,
  input  logic             add_cout_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             fault_o,
  output logic             valid_o,
  input  logic             res_ready_i
);

  localparam int              N      = WIDTH / 4;
  localparam int              KW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cin_q;
  logic             carry_q;
  logic             cout_q;
  logic             fault_q;
  logic             valid_q;
  logic             ready_q;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       sum_nib;
  logic             first_nib;
  logic             last_nib;
  logic             mismatch;

  // Current nibble of each stored operand / stored pass-1 sum.
  assign a_nib     = a_q[{k_q, 2'b00} +: 4];
  assign b_nib     = b_q[{k_q, 2'b00} +: 4];
  assign sum_nib   = sum_q[{k_q, 2'b00} +: 4];
  assign first_nib = (k_q == '0);
  assign last_nib  = (k_q == K_LAST);

  // Pass-2 disagreement with pass 1: nibble sum, plus carry-out on the last nibble.
  assign mismatch  = (add_sum_i != sum_nib) || (last_nib && (add_cout_i != cout_q));

  // Adder-slice drive decoded from registered state only; zero outside the passes.
  always_comb begin
    add_a_o   = 4'd0;
    add_b_o   = 4'd0;
    add_cin_o = 1'b0;
    if (state_q == PASS1) begin
      add_a_o   = a_nib;
      add_b_o   = b_nib;
      add_cin_o = first_nib ? cin_q : carry_q;
    end else if (state_q == PASS2) begin
      add_a_o   = b_nib;
      add_b_o   = a_nib;
      add_cin_o = first_nib ? cin_q : carry_q;
    end
  end

  // Sequencer: accept, two nibble-serial passes, then hold the result until taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      fault_q <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            cin_q   <= cin_i;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            fault_q <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            ready_q <= 1'b0;
            state_q <= PASS1;
          end
        end
        PASS1: begin
          sum_q[{k_q, 2'b00} +: 4] <= add_sum_i;
          carry_q                  <= add_cout_i;
          if (last_nib) begin
            cout_q <= add_cout_i;
            k_q    <= '0;
            if (REDUNDANT) begin
              state_q <= PASS2;
            end else begin
              state_q <= DONE;
              valid_q <= 1'b1;
            end
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        PASS2: begin
          // The carry register is reused: pass 2 restarts the chain from cin_q at k=0.
          carry_q <= add_cout_i;
          if (mismatch) begin
            fault_q <= 1'b1;
          end
          if (last_nib) begin
            k_q     <= '0;
            state_q <= DONE;
            valid_q <= 1'b1;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DONE: begin
          if (res_ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;
  assign fault_o = REDUNDANT ? fault_q : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_add_ctrl
// Description : Directed bench for nibble_serial_add_ctrl. Instance 1 is
//               redundant, instance 0 single-pass; each drives its own
//               behavioural 4-bit adder slice with optional sum-bit-0 upset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start     [2];
  logic        ready     [2];
  logic [15:0] a         [2];
  logic [15:0] b         [2];
  logic        cin       [2];
  logic [3:0]  add_a     [2];
  logic [3:0]  add_b     [2];
  logic        add_cin   [2];
  logic [3:0]  add_sum   [2];
  logic        add_cout  [2];
  logic [15:0] sum       [2];
  logic        cout      [2];
  logic        fault     [2];
  logic        valid     [2];
  logic        res_ready [2];
  logic        inj       [2];

  logic [3:0]  pa [16];
  logic [3:0]  pb [16];
  logic        pc [16];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(16), .REDUNDANT(1'b0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .ready_o(ready[0]),
    .a_i(a[0]), .b_i(b[0]), .cin_i(cin[0]),
    .add_a_o(add_a[0]), .add_b_o(add_b[0]), .add_cin_o(add_cin[0]),
    .add_sum_i(add_sum[0]), .add_cout_i(add_cout[0]),
    .sum_o(sum[0]), .cout_o(cout[0]), .fault_o(fault[0]), .valid_o(valid[0]),
    .res_ready_i(res_ready[0])
  );

  nibble_serial_add_ctrl #(.WIDTH(16), .REDUNDANT(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .ready_o(ready[1]),
    .a_i(a[1]), .b_i(b[1]), .cin_i(cin[1]),
    .add_a_o(add_a[1]), .add_b_o(add_b[1]), .add_cin_o(add_cin[1]),
    .add_sum_i(add_sum[1]), .add_cout_i(add_cout[1]),
    .sum_o(sum[1]), .cout_o(cout[1]), .fault_o(fault[1]), .valid_o(valid[1]),
    .res_ready_i(res_ready[1])
  );

  // Shared-slice models: true 4-bit ripple add, sum bit 0 flipped while inj is high.
  for (genvar g = 0; g < 2; g++) begin : g_add
    logic [4:0] s;
    always_comb begin
      s           = {1'b0, add_a[g]} + {1'b0, add_b[g]} + {4'b0000, add_cin[g]};
      add_sum[g]  = s[3:0] ^ {3'b000, inj[g]};
      add_cout[g] = s[4];
    end
  end

  typedef struct {
    int          d;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    int          inj_cyc;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input int d);
    check($sformatf("rst%0d valid", d), 32'(valid[d]), 32'd0);
    check($sformatf("rst%0d ready", d), 32'(ready[d]), 32'd1);
    check($sformatf("rst%0d sum", d), 32'(sum[d]), 32'd0);
    check($sformatf("rst%0d cout", d), 32'(cout[d]), 32'd0);
    check($sformatf("rst%0d fault", d), 32'(fault[d]), 32'd0);
    check($sformatf("rst%0d add", d), {23'd0, add_a[d], add_b[d], add_cin[d]}, 32'd0);
  endtask

  // Issue one operation; inj_cyc is the cycle after accept (0 = PASS1 k=0) to upset the slice.
  task automatic run_op(input int d, input logic [15:0] va, input logic [15:0] vb,
                        input logic vcin, input int inj_cyc, input logic [15:0] es,
                        input logic ec, input logic ef, input string tag);
    int lat;
    int exp_lat;
    bit got;
    exp_lat = (d == 1) ? 8 : 4;
    lat = 0;
    got = 1'b0;
    @(negedge clk);
    a[d] = va; b[d] = vb; cin[d] = vcin; start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    // Scramble operands so only the accept-edge sample can produce the right answer.
    a[d] = 16'hDEAD; b[d] = 16'hBEEF; cin[d] = ~vcin;
    check({tag, " busy"}, 32'(ready[d]), 32'd0);
    inj[d] = (inj_cyc == 0);
    pa[0] = add_a[d]; pb[0] = add_b[d]; pc[0] = add_cin[d];
    for (int j = 1; j <= exp_lat + 8 && !got; j++) begin
      @(posedge clk); #1;
      inj[d] = (j == inj_cyc);
      if (j < 16) begin
        pa[j] = add_a[d]; pb[j] = add_b[d]; pc[j] = add_cin[d];
      end
      if (valid[d]) begin
        got = 1'b1;
        lat = j;
      end
    end
    inj[d] = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " sum"}, 32'(sum[d]), 32'(es));
    check({tag, " cout"}, 32'(cout[d]), 32'(ec));
    check({tag, " fault"}, 32'(fault[d]), 32'(ef));
    check({tag, " done drive"}, {27'd0, add_a[d], add_cin[d]}, 32'd0);
  endtask

  task automatic release_res(input int d, input logic [15:0] es, input string tag);
    @(negedge clk);
    res_ready[d] = 1'b1;
    @(posedge clk); #1;
    res_ready[d] = 1'b0;
    check({tag, " rel valid"}, 32'(valid[d]), 32'd0);
    check({tag, " rel ready"}, 32'(ready[d]), 32'd1);
    check({tag, " rel sum hold"}, 32'(sum[d]), 32'(es));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    // d, a, b, cin, inj cycle, expected sum, cout, fault
    vecs[0] = '{1, 16'hFFFF, 16'h0001, 1'b0, -1, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{1, 16'h1234, 16'h4321, 1'b1, -1, 16'h5556, 1'b0, 1'b0};
    vecs[2] = '{1, 16'h00FF, 16'h0F01, 1'b0,  6, 16'h1000, 1'b0, 1'b1};
    vecs[3] = '{1, 16'h1234, 16'h4321, 1'b1,  4, 16'h5556, 1'b0, 1'b1};
    vecs[4] = '{1, 16'h0000, 16'h0000, 1'b0,  1, 16'h0010, 1'b0, 1'b1};
    vecs[5] = '{1, 16'hFFFF, 16'hFFFF, 1'b1, -1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{1, 16'hABCD, 16'h5432, 1'b0, -1, 16'hFFFF, 1'b0, 1'b0};
    vecs[7] = '{0, 16'h8000, 16'h8000, 1'b0, -1, 16'h0000, 1'b1, 1'b0};
    // Single-pass upset at PASS1 k=2 corrupts the stored nibble yet never raises fault.
    vecs[8] = '{0, 16'h00FF, 16'h0F01, 1'b0,  2, 16'h1100, 1'b0, 1'b0};
    vecs[9] = '{0, 16'h0000, 16'h0000, 1'b0, -1, 16'h0000, 1'b0, 1'b0};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; a[d] = '0; b[d] = '0; cin[d] = 1'b0;
      res_ready[d] = 1'b0; inj[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].inj_cyc,
             vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_fault, $sformatf("v%0d", i));
      if (i == 1) begin
        check("v1 p1 k0 cin", 32'(pc[0]), 32'd1);
        check("v1 p1 k3 a", 32'(pa[3]), 32'h1);
        check("v1 p1 k3 b", 32'(pb[3]), 32'h4);
        check("v1 p2 k0 cin", 32'(pc[4]), 32'd1);
        check("v1 p2 k3 a", 32'(pa[7]), 32'h4);
        check("v1 p2 k3 b", 32'(pb[7]), 32'h1);
      end
      release_res(vecs[i].d, vecs[i].exp_sum, $sformatf("v%0d", i));
    end

    // Back-pressure in DONE: result held, new request ignored and not queued.
    run_op(1, 16'h1234, 16'h4321, 1'b1, -1, 16'h5556, 1'b0, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start[1] = (i == 2);
      a[1] = 16'h0001; b[1] = 16'h0001;
      @(posedge clk); #1;
      check($sformatf("bp%0d valid", i), 32'(valid[1]), 32'd1);
      check($sformatf("bp%0d sum", i), 32'(sum[1]), 32'h5556);
      check($sformatf("bp%0d ready", i), 32'(ready[1]), 32'd0);
    end
    start[1] = 1'b0;
    release_res(1, 16'h5556, "bp");
    @(posedge clk); #1;
    check("bp not queued", {30'd0, ready[1], valid[1]}, 32'd2);

    // Reset during PASS1 k=1: operation dropped, outputs at reset values at once.
    @(negedge clk);
    a[1] = 16'h1234; b[1] = 16'h4321; cin[1] = 1'b0; start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    @(posedge clk); #1;
    check("mid k1 add_a", 32'(add_a[1]), 32'h3);
    rst_n = 1'b0;
    #1;
    check_reset(1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (valid[1]) seen++;
    end
    check("no valid after reset", 32'(seen), 32'd0);
    run_op(1, 16'h1234, 16'h4321, 1'b1, -1, 16'h5556, 1'b0, 1'b0, "post");
    release_res(1, 16'h5556, "post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
